// File: rtl/mio_bus_resp_if.sv
// rtl/mio_bus_resp_if.sv - CPU memory-IO request/response bus between CPU and responder
interface mio_bus_resp_if;
  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic [31:0] Data_in;
  logic        MIO_ready;
  logic        err;

  modport master (
    output CPU_MIO, mem_w, Addr_out, Data_out,
    input  Data_in, MIO_ready, err
  );

  modport slave (
    input  CPU_MIO, mem_w, Addr_out, Data_out,
    output Data_in, MIO_ready, err
  );
endinterface

// File: rtl/mio_bus_resp.sv
// rtl/mio_bus_resp.sv - word memory responder with wait states; MIO_RESP_ERR_EN adds out-of-range error responses
module mio_bus_resp #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_WIDTH  = 10
) (
  input logic           clk,
  input logic           reset,
  mio_bus_resp_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [31:0]             data_in_q;
  logic                    capture;
  logic                    enter_resp;
  logic                    cur_wr;
  logic                    cur_oor;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [31:0]             cur_wdata;
  logic [31:0]             mem [DEPTH];

`ifdef MIO_RESP_ERR_EN
  logic oor_q;
  logic in_oor;
  assign in_oor = (bus.Addr_out >> (ADDR_WIDTH + 2)) != 32'd0;
`endif

  assign capture    = (state_q == S_IDLE) && bus.CPU_MIO;
  assign enter_resp = (state_d == S_RESP);

  // With zero wait states RESP is entered on the capture edge itself, so use the live inputs then
  assign cur_wr    = (state_q == S_IDLE) ? bus.mem_w : wr_q;
  assign cur_addr  = (state_q == S_IDLE) ? bus.Addr_out[ADDR_WIDTH+1:2] : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? bus.Data_out : wdata_q;
`ifdef MIO_RESP_ERR_EN
  assign cur_oor   = (state_q == S_IDLE) ? in_oor : oor_q;
`else
  assign cur_oor   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.CPU_MIO) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_HOLD;
      S_HOLD:  if (!bus.CPU_MIO) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.MIO_ready = (state_q == S_RESP);
    bus.Data_in   = data_in_q;
`ifdef MIO_RESP_ERR_EN
    bus.err       = (state_q == S_RESP) && oor_q;
`else
    bus.err       = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
`ifdef MIO_RESP_ERR_EN
      oor_q   <= 1'b0;
`endif
    end else if (capture) begin
      wr_q    <= bus.mem_w;
      addr_q  <= bus.Addr_out[ADDR_WIDTH+1:2];
      wdata_q <= bus.Data_out;
`ifdef MIO_RESP_ERR_EN
      oor_q   <= in_oor;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_in_q <= 32'h0;
    end else if (enter_resp && !cur_wr) begin
      data_in_q <= cur_oor ? 32'hDEADBEEF : mem[cur_addr];
    end
  end

  // Memory has no reset: contents survive reset and start undefined
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && cur_wr && !cur_oor) begin
      mem[cur_addr] <= cur_wdata;
    end
  end
endmodule

// File: tb/tb_mio_bus_resp.sv
// tb/tb_mio_bus_resp.sv - randomized bench for mio_bus_resp against a transaction-level memory model
module tb_mio_bus_resp;
  localparam int W  = 2;
  localparam int AW = 10;

  logic clk;
  logic reset;
  int   cyc;
  logic rst_seen;
  bit   started;
  int   n_pass;
  int   n_tot;

  mio_bus_resp_if bus_a ();
  mio_bus_resp_if bus_b ();

  mio_bus_resp #(.WAIT_CYCLES(W), .ADDR_WIDTH(AW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  mio_bus_resp #(.WAIT_CYCLES(0), .ADDR_WIDTH(AW)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  typedef struct {
    int          cyc;
    bit          wr;
    int          word;
    logic [31:0] data;
    bit          oor;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] mem_m[int];
  logic [31:0] exp_data;
  bit          data_known;
  logic        exp_rdy;
  logic        exp_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic bit is_oor(input logic [31:0] a);
`ifdef MIO_RESP_ERR_EN
    return (a / 32'h1000) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % (1 << AW));
  endfunction

  always @(negedge clk) begin
    if (started) begin
      exp_rdy = 1'b0;
      exp_err = 1'b0;
      if (rst_seen) begin
        pend.delete();
        exp_data   = 32'h0;
        data_known = 1'b1;
      end else if (pend.size() > 0 && pend[0].cyc == cyc) begin
        pend_t p;
        p = pend.pop_front();
        exp_rdy = 1'b1;
        if (p.oor) begin
          exp_err = 1'b1;
          if (!p.wr) exp_data = 32'hDEADBEEF;
        end else if (p.wr) begin
          mem_m[p.word] = p.data;
        end else if (mem_m.exists(p.word)) begin
          exp_data   = mem_m[p.word];
          data_known = 1'b1;
        end else begin
          data_known = 1'b0;
        end
      end
      chk("ready", {31'h0, bus_a.MIO_ready}, {31'h0, exp_rdy});
      chk("err", {31'h0, bus_a.err}, {31'h0, exp_err});
      if (data_known) chk("data_in", bus_a.Data_in, exp_data);
    end
  end

  task automatic perturb(input bit keep_req);
    bus_a.CPU_MIO  = keep_req;
    bus_a.mem_w    = 1'($urandom_range(0, 1));
    bus_a.Addr_out = $urandom;
    bus_a.Data_out = $urandom;
  endtask

  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input int extra, input bit drop,
                     output logic rdy, output logic [31:0] rd, output logic er);
    int a;
    @(negedge clk);
    a = cyc;
    bus_a.CPU_MIO  = 1'b1;
    bus_a.mem_w    = wr;
    bus_a.Addr_out = addr;
    bus_a.Data_out = data;
    pend.push_back('{a + W + 1, wr, word_of(addr), data, is_oor(addr)});
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (k == 1) perturb(!drop);
      if (k == W + 1) begin
        rdy = bus_a.MIO_ready;
        rd  = bus_a.Data_in;
        er  = bus_a.err;
      end
    end
    for (int k = 0; k < extra; k++) begin
      @(negedge clk);
      perturb(!drop);
    end
    @(negedge clk);
    perturb(1'b0);
  endtask

  task automatic reset_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input int at);
    int a;
    @(negedge clk);
    a = cyc;
    bus_a.CPU_MIO  = 1'b1;
    bus_a.mem_w    = wr;
    bus_a.Addr_out = addr;
    bus_a.Data_out = data;
    pend.push_back('{a + W + 1, wr, word_of(addr), data, is_oor(addr)});
    repeat (at) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_a.CPU_MIO = 1'b0;
    chk("rst_data_in", bus_a.Data_in, 32'h0);
    chk("rst_ready", {31'h0, bus_a.MIO_ready}, 32'h0);
  endtask

  initial begin
    logic        rdy;
    logic [31:0] rd;
    logic        er;
    n_pass = 0;
    n_tot  = 0;
    cyc    = 0;
    started = 1'b0;
    data_known = 1'b1;
    exp_data = 32'h0;
    reset  = 1'b1;
    bus_a.CPU_MIO = 1'b0; bus_a.mem_w = 1'b0; bus_a.Addr_out = 32'h0; bus_a.Data_out = 32'h0;
    bus_b.CPU_MIO = 1'b0; bus_b.mem_w = 1'b0; bus_b.Addr_out = 32'h0; bus_b.Data_out = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_ready", {31'h0, bus_a.MIO_ready}, 32'h0);
    chk("reset_data", bus_a.Data_in, 32'h0);
    chk("reset_err", {31'h0, bus_a.err}, 32'h0);
    started = 1'b1;

    for (int w = 0; w < 8; w++) txn(1'b1, 32'(w * 4), 32'h1000_0000 + 32'(w), 0, 1'b0, rdy, rd, er);

    txn(1'b1, 32'h40, 32'h12345678, 0, 1'b0, rdy, rd, er);
    chk("wr40_lat3", {31'h0, rdy}, 32'h1);
    txn(1'b0, 32'h40, 32'h0, 0, 1'b0, rdy, rd, er);
    chk("rd40_lat3", {31'h0, rdy}, 32'h1);
    chk("rd40_data", rd, 32'h12345678);

    txn(1'b0, 32'h4, 32'h0, 5, 1'b0, rdy, rd, er);
    chk("hold_rd4", rd, 32'h1000_0001);
    txn(1'b0, 32'h40, 32'h0, 0, 1'b1, rdy, rd, er);
    chk("drop_rd40", rd, 32'h12345678);

    reset_txn(1'b1, 32'h8, 32'hFFFFFFFF, 1);
    txn(1'b0, 32'h8, 32'h0, 0, 1'b0, rdy, rd, er);
    chk("rd8_after_rst", rd, 32'h1000_0002);
    reset_txn(1'b1, 32'hC, 32'hFFFFFFFF, W);
    txn(1'b0, 32'hC, 32'h0, 0, 1'b0, rdy, rd, er);
    chk("rdC_resp_rst", rd, 32'h1000_0003);

    txn(1'b1, 32'h0, 32'h11110000, 0, 1'b0, rdy, rd, er);
    txn(1'b1, 32'h1000, 32'hA5A5A5A5, 0, 1'b0, rdy, rd, er);
    txn(1'b0, 32'h1000, 32'h0, 0, 1'b0, rdy, rd, er);
`ifdef MIO_RESP_ERR_EN
    chk("oor_err", {31'h0, er}, 32'h1);
    chk("oor_data", rd, 32'hDEADBEEF);
    txn(1'b0, 32'h0, 32'h0, 0, 1'b0, rdy, rd, er);
    chk("w0_kept", rd, 32'h11110000);
`else
    chk("oor_err", {31'h0, er}, 32'h0);
    chk("alias_data", rd, 32'hA5A5A5A5);
    txn(1'b0, 32'h0, 32'h0, 0, 1'b0, rdy, rd, er);
    chk("w0_alias", rd, 32'hA5A5A5A5);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [31:0] addr;
      addr = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) addr = addr + (32'($urandom_range(1, 7)) << 12);
      if (i % 10 == 9)
        reset_txn(1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(1, W));
      else
        txn(1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 2),
            1'($urandom_range(0, 1)), rdy, rd, er);
    end

    @(negedge clk);
    bus_b.CPU_MIO = 1'b1; bus_b.mem_w = 1'b1; bus_b.Addr_out = 32'h0; bus_b.Data_out = 32'hCAFEF00D;
    @(negedge clk);
    chk("w0_wr_ready", {31'h0, bus_b.MIO_ready}, 32'h1);
    bus_b.CPU_MIO = 1'b0;
    @(negedge clk);
    chk("w0_hold_ready", {31'h0, bus_b.MIO_ready}, 32'h0);
    @(negedge clk);
    bus_b.CPU_MIO = 1'b1; bus_b.mem_w = 1'b0; bus_b.Data_out = 32'h0;
    @(negedge clk);
    chk("w0_rd_ready", {31'h0, bus_b.MIO_ready}, 32'h1);
    chk("w0_rd_data", bus_b.Data_in, 32'hCAFEF00D);
    bus_b.CPU_MIO = 1'b0;
    @(negedge clk);
    chk("w0_rd_done", {31'h0, bus_b.MIO_ready}, 32'h0);
    chk("w0_data_held", bus_b.Data_in, 32'hCAFEF00D);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mio_bus_resp.md
MIO_BUS_RESP -- requirements
Module: mio_bus_resp

Interface
REQ-001 The module SHALL have parameter WAIT_CYCLES, default 2: wait states inserted before each response (0..15).
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 10: log2 of memory depth in 32-bit words.
REQ-003 The module SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port CPU_MIO  input  1  request strobe from the CPU, level-held until MIO_ready is seen.
REQ-006 The module SHALL have port mem_w  input  1  1 = write, 0 = read; sampled with the request.
REQ-007 The module SHALL have port Addr_out  input  32  byte address; word index = Addr_out[ADDR_WIDTH+1:2], bits [1:0] ignored.
REQ-008 The module SHALL have port Data_out  input  32  write data.
REQ-009 The module SHALL have port Data_in  output  32  registered read data to the CPU.
REQ-010 The module SHALL have port MIO_ready  output  1  one-cycle response pulse.
REQ-011 The module SHALL have port err  output  1  address-error flag, valid with MIO_ready.

Function
REQ-012 The module SHALL implement the FSM states IDLE, WAIT, RESP and HOLD.
REQ-013 In IDLE with CPU_MIO=1, the module SHALL capture mem_w, Addr_out and Data_out, then go to WAIT with count=WAIT_CYCLES-1, or directly to RESP if WAIT_CYCLES=0.
REQ-014 In WAIT, the count SHALL decrement each cycle; at count 0 the FSM SHALL go to RESP, so exactly WAIT_CYCLES cycles are spent in WAIT.
REQ-015 On the edge entering RESP, a write SHALL commit the captured data to the captured word, and a read SHALL load Data_in from that word.
REQ-016 MIO_ready SHALL equal 1 only while the FSM is in RESP; the latency from the capture edge to MIO_ready high SHALL be WAIT_CYCLES+1 cycles.
REQ-017 RESP SHALL last exactly one cycle, then go to HOLD.
REQ-018 HOLD SHALL return to IDLE on the first cycle CPU_MIO=0; no new request SHALL be accepted until CPU_MIO has been seen low.
REQ-019 Data_in SHALL hold the last read value through writes and idle cycles; it changes only on a read response or on reset.
REQ-020 Deasserting CPU_MIO during WAIT SHALL NOT abort the transaction; it completes with the captured values.
REQ-021 Input changes after capture SHALL be ignored until the next IDLE capture.
REQ-022 Memory contents SHALL be unaffected by reset and undefined at power-up.

Reset
REQ-023 When reset=1 at a rising edge, the module SHALL force the FSM to IDLE, the wait count to 0, MIO_ready=0, Data_in=32'h0 and err=0.
REQ-024 Reset SHALL take priority over all other activity.
REQ-025 A request in WAIT when reset asserts SHALL be discarded with no memory write.
REQ-026 Reset coinciding with the RESP entry edge SHALL suppress the write and the Data_in load.

Configuration
REQ-027 With macro MIO_RESP_ERR_EN defined, a request with Addr_out[31:ADDR_WIDTH+2] != 0 SHALL complete with normal timing, with err=1 during RESP, the write suppressed, and Data_in loaded with 32'hDEADBEEF on reads.
REQ-028 With MIO_RESP_ERR_EN undefined, err SHALL be tied to 0 and out-of-range addresses SHALL alias modulo 2^ADDR_WIDTH words.

Verification
REQ-029 Write then read: write 0x12345678 to 0x40, then read 0x40 with WAIT_CYCLES=2 -> MIO_ready high exactly 3 cycles after each capture and Data_in=0x12345678 in the read RESP cycle.
REQ-030 WAIT_CYCLES=0: read of a preloaded word 0xCAFEF00D at 0x0 -> MIO_ready high in the cycle right after capture, Data_in=0xCAFEF00D.
REQ-031 CPU_MIO held high 5 cycles past MIO_ready -> exactly one MIO_ready pulse, FSM stays in HOLD, and a second pulse comes only after CPU_MIO drops and rises again.
REQ-032 Reset asserted in WAIT during a write of 0xFFFFFFFF to 0x8 -> no MIO_ready, a following read of 0x8 returns the old value, and Data_in=0 right after reset.
REQ-033 Out-of-range write then read at 0x00001000 with ADDR_WIDTH=10 -> with MIO_RESP_ERR_EN: err=1, read returns 0xDEADBEEF, word 0 unchanged; without it: err=0 and the access aliases to word 0.
